// File: rtl/pc_unit.sv
// Program-counter unit: sequential next-PC, prioritised redirects (trap, mret, jump, branch),
// exception PC capture and a small circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int              BITS         = 64,
  parameter logic [BITS-1:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FFFC,
  parameter logic [BITS-1:0] TRAP_VECTOR  = 64'h0000_0000_0000_0100,
  parameter int              RAS_DEPTH    = 4,
  parameter bit              COMPRESSED   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            is_compressed,
  input  logic            branch_taken,
  input  logic [BITS-1:0] branch_target,
  input  logic            jump,
  input  logic [BITS-1:0] jump_target,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            trap_req,
  input  logic            mret,
  output logic [BITS-1:0] pc_out,
  output logic [BITS-1:0] pc_plus,
  output logic [BITS-1:0] epc_out,
  output logic            misaligned,
  output logic [BITS-1:0] ras_top,
  output logic            ras_valid
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [BITS-1:0] pc_q, pc_d;
  logic [BITS-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;
  logic [BITS-1:0] ras_q [RAS_DEPTH];
  logic [BITS-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] step;
  logic            jump_mis, branch_mis;

  function automatic logic is_misaligned(input logic [BITS-1:0] addr);
    if (COMPRESSED) return addr[0];
    else            return |addr[1:0];
  endfunction

  always_comb begin
    step       = (COMPRESSED && is_compressed) ? BITS'(2) : BITS'(4);
    pc_plus    = pc_q + step;
    jump_mis   = is_misaligned(jump_target);
    branch_mis = is_misaligned(branch_target);
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    mis_d = 1'b0;
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (trap_req) begin
      pc_d  = TRAP_VECTOR;
      epc_d = pc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (mret) begin
      pc_d = epc_q;
    end else if (jump) begin
      if (jump_mis) begin
        pc_d  = TRAP_VECTOR;
        epc_d = pc_q;
        mis_d = 1'b1;
      end else begin
        pc_d = jump_target;
        // Call+ret replaces the top in place; an empty stack then holds just that entry.
        if (is_call && is_ret) begin
          ras_d[ptr_q] = pc_plus;
          if (cnt_q == '0) cnt_d = CW'(1);
        end else if (is_call) begin
          if (cnt_q != '0) ptr_d = ptr_q + PW'(1);
          ras_d[ptr_d] = pc_plus;
          if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (is_ret) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q != CW'(1)) ptr_d = ptr_q - PW'(1);
          end
        end
      end
    end else if (branch_taken) begin
      if (branch_mis) begin
        pc_d  = TRAP_VECTOR;
        epc_d = pc_q;
        mis_d = 1'b1;
      end else begin
        pc_d = branch_target;
      end
    end else begin
      pc_d = pc_plus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
    end
  end

  assign pc_out     = pc_q;
  assign epc_out    = epc_q;
  assign misaligned = mis_q;
  assign ras_valid  = (cnt_q != '0);
  assign ras_top    = (cnt_q != '0) ? ras_q[ptr_q] : '0;

endmodule
